// File: rtl/decoder_if.sv
// ---------------------------------------------------------------------------
// decoder_if
// Bundles the data-side signals of the decoder so an environment can carry
// them around as one object. clock and reset_n are not part of the bundle.
//
// Signals:
//   stream   - select index driven towards the decoder
//   en       - capture enable for the registered path
//   label    - combinational one-hot decode of stream
//   label_q  - registered one-hot decode of the captured index
//   index_q  - registered copy of the captured index
//   valid_q  - at least one capture since reset
//   changed  - one-cycle pulse when a capture loaded a different index
//
// Modports:
//   master - the side that drives stream/en and observes the results
//   slave  - the decoder side
// ---------------------------------------------------------------------------
interface decoder_if #(
   parameter int SEL_W = 5,
   localparam int OUT_W = 2 ** SEL_W
);
   logic [SEL_W-1:0] stream;
   logic             en;
   logic [OUT_W-1:0] label;
   logic [OUT_W-1:0] label_q;
   logic [SEL_W-1:0] index_q;
   logic             valid_q;
   logic             changed;

   modport master (
      output stream,
      output en,
      input  label,
      input  label_q,
      input  index_q,
      input  valid_q,
      input  changed
   );

   modport slave (
      input  stream,
      input  en,
      output label,
      output label_q,
      output index_q,
      output valid_q,
      output changed
   );
endinterface

// File: rtl/decoder.sv
// ---------------------------------------------------------------------------
// decoder
// SEL_W-bit to 2**SEL_W one-hot decoder with a combinational output and a
// registered capture path.
//
// Ports (declaration order is fixed so that a positional (label, stream)
// instance still elaborates):
//   label    out OUT_W  combinational one-hot of stream, independent of
//                       clock, reset_n and en
//   stream   in  SEL_W  select index
//   clock    in  1      rising-edge clock
//   reset_n  in  1      asynchronous active-low reset; deassertion must be
//                       synchronised by the integrator
//   en       in  1      capture enable
//   label_q  out OUT_W  registered one-hot of index_q, zero until valid_q
//   index_q  out SEL_W  last captured stream
//   valid_q  out 1      high once a capture has happened since reset
//   changed  out 1      one-cycle pulse after a capture that loaded a
//                       different index than the previous capture
// ---------------------------------------------------------------------------
module decoder #(
   parameter int SEL_W = 5,
   localparam int OUT_W = 2 ** SEL_W
) (
   output logic [OUT_W-1:0] label,
   input  logic [SEL_W-1:0] stream,
   input  logic             clock,
   input  logic             reset_n,
   input  logic             en,
   output logic [OUT_W-1:0] label_q,
   output logic [SEL_W-1:0] index_q,
   output logic             valid_q,
   output logic             changed
);

   // One-hot of an index. Shifting a single set bit means an unknown index
   // propagates as an all-unknown result in 4-state simulation, and the
   // expression is plain combinational logic with no latch.
   function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] idx);
      logic [OUT_W-1:0] one_s;
      one_s = {{(OUT_W-1){1'b0}}, 1'b1};
      return one_s << idx;
   endfunction

   logic [OUT_W-1:0] label_s;
   logic [OUT_W-1:0] label_r;
   logic [SEL_W-1:0] index_r;
   logic             valid_r;
   logic             changed_r;

   // Combinational decode of the live select; deliberately untouched by
   // reset so it keeps tracking stream while the registers are cleared.
   always_comb begin
      label_s = onehot(stream);
   end

   // Capture path: load on en, hold otherwise. changed compares against the
   // previously captured index only when one exists, so the first capture
   // after reset never pulses.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         label_r   <= {OUT_W{1'b0}};
         index_r   <= {SEL_W{1'b0}};
         valid_r   <= 1'b0;
         changed_r <= 1'b0;
      end else if (en) begin
         label_r   <= onehot(stream);
         index_r   <= stream;
         valid_r   <= 1'b1;
         changed_r <= valid_r && (stream != index_r);
      end else begin
         label_r   <= label_r;
         index_r   <= index_r;
         valid_r   <= valid_r;
         changed_r <= 1'b0;
      end
   end

   assign label   = label_s;
   assign label_q = label_r;
   assign index_q = index_r;
   assign valid_q = valid_r;
   assign changed = changed_r;

endmodule

// File: tb/tb_decoder.sv
// ---------------------------------------------------------------------------
// tb_decoder
// Self-checking bench for decoder: directed boundary/reset scenarios followed
// by randomized select/enable traffic, compared against a reference model
// that tracks "last captured index" as a plain integer and computes one-hot
// values as powers of two.
// ---------------------------------------------------------------------------
module tb_decoder;

   logic clock;
   logic reset_n;

   int checks;
   int errors;

   // reference model state
   int m_idx;
   bit m_has;
   bit m_chg;

   decoder_if #(.SEL_W(5)) dif ();

   decoder #(.SEL_W(5)) dut (
      .label   (dif.label),
      .stream  (dif.stream),
      .clock   (clock),
      .reset_n (reset_n),
      .en      (dif.en),
      .label_q (dif.label_q),
      .index_q (dif.index_q),
      .valid_q (dif.valid_q),
      .changed (dif.changed)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // 2**n computed by repeated doubling
   function automatic logic [31:0] pow2(input int n);
      longint p;
      p = 1;
      repeat (n) p = p * 2;
      return p[31:0];
   endfunction

   function automatic logic [31:0] exp_label_q();
      return m_has ? pow2(m_idx) : 32'h0;
   endfunction

   task automatic model_reset();
      m_idx = 0;
      m_has = 1'b0;
      m_chg = 1'b0;
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".label_q"}, dif.label_q, exp_label_q());
      check({tag, ".index_q"}, {27'd0, dif.index_q}, m_idx[31:0]);
      check({tag, ".valid_q"}, {31'd0, dif.valid_q}, {31'd0, m_has});
      check({tag, ".changed"}, {31'd0, dif.changed}, {31'd0, m_chg});
   endtask

   // drive inputs, check the combinational decode, clock once, update the
   // model and check the registered outputs just after the edge
   task automatic step(input int s, input bit e, input string tag);
      dif.stream = s[4:0];
      dif.en     = e;
      #1;
      check({tag, ".label"}, dif.label, pow2(s));
      @(posedge clock);
      if (e) begin
         m_chg = m_has && (s != m_idx);
         m_idx = s;
         m_has = 1'b1;
      end else begin
         m_chg = 1'b0;
      end
      #1;
      check_regs(tag);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      model_reset();
      reset_n    = 1'b0;
      dif.stream = 5'd0;
      dif.en     = 1'b0;
      #2;
      check_regs("reset");

      // full sweep while reset is held: label must ignore reset_n
      for (int i = 0; i < 32; i++) begin
         dif.stream = i[4:0];
         #1;
         check("sweep.label", dif.label, pow2(i));
         check("sweep.onehot", $countones(dif.label), 32'd1);
      end
      dif.stream = 5'd0;
      #1;
      check("bound.zero", dif.label, 32'h0000_0001);
      dif.stream = 5'd31;
      #1;
      check("bound.top", dif.label, 32'h8000_0000);

      @(negedge clock);
      reset_n = 1'b1;

      // same index twice: no change pulse
      step(7, 1'b1, "same7a");
      check("same7a.lq", dif.label_q, 32'h0000_0080);
      check("same7a.chg", {31'd0, dif.changed}, 32'd0);
      step(7, 1'b1, "same7b");
      check("same7b.chg", {31'd0, dif.changed}, 32'd0);

      // 3 then 9: one pulse after the 9 capture
      step(3, 1'b1, "cap3");
      step(9, 1'b1, "cap9");
      check("cap9.chg", {31'd0, dif.changed}, 32'd1);
      check("cap9.idx", {27'd0, dif.index_q}, 32'd9);
      step(9, 1'b0, "hold9");
      check("hold9.chg", {31'd0, dif.changed}, 32'd0);

      // en low while stream toggles: registers hold
      step(5, 1'b0, "hold5");
      step(12, 1'b0, "hold12");
      check("hold12.idx", {27'd0, dif.index_q}, 32'd9);

      // async reset mid-run with label_q = 0x400
      step(10, 1'b1, "cap10");
      check("cap10.lq", dif.label_q, 32'h0000_0400);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_regs("async_rst");
      dif.stream = 5'd17;
      #1;
      check("rst.label", dif.label, 32'h0002_0000);
      @(negedge clock);
      reset_n = 1'b1;
      step(20, 1'b1, "first_after_rst");
      check("first.chg", {31'd0, dif.changed}, 32'd0);

      // alternating indices on consecutive enabled cycles
      step(4, 1'b1, "alt4");
      check("alt4.chg", {31'd0, dif.changed}, 32'd1);
      step(6, 1'b1, "alt6");
      check("alt6.chg", {31'd0, dif.changed}, 32'd1);

      // randomized traffic, biased towards repeating the captured index
      for (int n = 0; n < 300; n++) begin
         int s;
         bit e;
         s = ($urandom_range(0, 3) == 0) ? m_idx : int'($urandom_range(0, 31));
         e = ($urandom_range(0, 2) != 0);
         step(s, e, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
